// File: rtl/bin_cnt_down_pkg.sv
// Shared state encoding and defaults for the bin_cnt_down timer.
// Imported by bin_cnt_down and sub_by_1.
package bin_cnt_down_pkg;

  localparam int BCD_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/bin_cnt_down_sub.sv
// sub_by_1: gate-level combinational decrement (ripple borrow chain).
// Ports: A in, diff = A-1 out, borrow_out high only when A == 0.
module sub_by_1
  import bin_cnt_down_pkg::*;
#(
  parameter int WIDTH = BCD_WIDTH
) (
  input  logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  logic [WIDTH:0] b;

  assign b[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign b[i+1]  = b[i] & ~A[i];
    assign diff[i] = A[i] ^ b[i];
  end

  assign borrow_out = b[WIDTH];

endmodule

// File: rtl/bin_cnt_down.sv
// bin_cnt_down: loadable enable-gated down counter / timeout timer.
// Ports: clk, rst_n, load, load_val, start, en -> count, busy, tc.
// BIN_CNT_DOWN_RELOAD_EN adds input reload and a shadow register.
module bin_cnt_down
  import bin_cnt_down_pkg::*;
#(
  parameter int WIDTH = BCD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             en,
`ifdef BIN_CNT_DOWN_RELOAD_EN
  input  logic             reload,
`endif
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc
);

  state_t           state;
  logic [WIDTH-1:0] dec;
  logic             unused_borrow;
  logic             gt1;

  sub_by_1 #(
    .WIDTH(WIDTH)
  ) u_sub (
    .A         (count),
    .diff      (dec),
    .borrow_out(unused_borrow)
  );

  assign gt1 = |count[WIDTH-1:1];

`ifdef BIN_CNT_DOWN_RELOAD_EN
  logic [WIDTH-1:0] shadow;
  logic             tc_rl;
  logic             rl_hit;

  assign rl_hit = reload && (shadow != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= '0;
      shadow <= '0;
      tc_rl  <= 1'b0;
    end else begin
      tc_rl <= 1'b0;
      if (load) begin
        count  <= load_val;
        shadow <= load_val;
        state  <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (start)
              state <= (count != '0) ? RUN : DONE;
          end
          RUN: begin
            if (en) begin
              if (gt1) begin
                count <= dec;
              end else if (rl_hit) begin
                // wrap back to the period, stay busy
                count <= shadow;
                tc_rl <= 1'b1;
              end else begin
                count <= '0;
                state <= DONE;
              end
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign tc = (state == DONE) | tc_rl;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
    end else if (load) begin
      count <= load_val;
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start)
            state <= (count != '0) ? RUN : DONE;
        end
        RUN: begin
          if (en) begin
            if (gt1) begin
              count <= dec;
            end else begin
              count <= '0;
              state <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign tc = (state == DONE);
`endif

  assign busy = (state == RUN);

endmodule
